// File: rtl/round_robin_arbiter.sv
// N-way arbiter with zero-latency combinational grant: fixed-priority or round-robin
// search from a registered pointer, with optional grant hold for the current owner.
module round_robin_arbiter #(
  parameter int N    = 32,
  parameter int MODE = 1,
  parameter int HOLD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req_i,
  output logic [N-1:0]         gnt_o,
  output logic                 gnt_valid_o,
  output logic [$clog2(N)-1:0] gnt_idx_o
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] own_q, own_d;
  logic          own_v_q, own_v_d;

  logic [IW-1:0]  start;
  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic           found;
  logic [IW:0]    ofs;
  logic [IW:0]    sum;
  logic [IW-1:0]  win;
  logic [IW:0]    win_inc;
  logic           hold_hit;
  logic           new_gnt;

  // Rotate requests so the search always scans upward from bit 0 of req_rot.
  always_comb begin
    start   = (MODE == 1) ? ptr_q : '0;
    req_dbl = {req_i, req_i} >> start;
    req_rot = req_dbl[N-1:0];
    found   = 1'b0;
    ofs     = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_rot[i]) begin
        found = 1'b1;
        ofs   = (IW+1)'(i);
      end
    end
    sum = {1'b0, start} + ofs;
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    win     = sum[IW-1:0];
    win_inc = {1'b0, win} + (IW+1)'(1);
    if (win_inc == (IW+1)'(N)) win_inc = '0;
  end

  always_comb begin
    hold_hit    = (HOLD != 0) && own_v_q && req_i[own_q];
    new_gnt     = 1'b0;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    if (!reset) begin
      if (hold_hit) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = own_q;
      end else if (found) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = win;
        new_gnt     = 1'b1;
      end
    end
    gnt_o = gnt_valid_o ? (N'(1) << gnt_idx_o) : '0;
  end

  always_comb begin
    ptr_d   = ptr_q;
    own_d   = own_q;
    own_v_d = own_v_q;
    if (new_gnt && MODE == 1) ptr_d = win_inc[IW-1:0];
    if (HOLD != 0) begin
      // A new grant always re-captures ownership, even in the cycle the old owner drops.
      if (new_gnt) begin
        own_d   = win;
        own_v_d = 1'b1;
      end else if (!req_i[own_q]) begin
        own_v_d = 1'b0;
      end
    end else begin
      own_d   = '0;
      own_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      own_q   <= '0;
      own_v_q <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      own_v_q <= own_v_d;
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed checks of several arbiter configurations plus a randomized N=32
// round-robin run against a pointer reference model.
module tb_round_robin_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  logic [3:0]  req_a = '0, gnt_a;  logic [1:0] idx_a; logic val_a;
  logic [3:0]  req_b = '0, gnt_b;  logic [1:0] idx_b; logic val_b;
  logic [3:0]  req_c = '0, gnt_c;  logic [1:0] idx_c; logic val_c;
  logic [4:0]  req_e = '0, gnt_e;  logic [2:0] idx_e; logic val_e;
  logic [31:0] req_d = '0, gnt_d;  logic [4:0] idx_d; logic val_d;

  round_robin_arbiter #(.N(4), .MODE(1), .HOLD(0)) u_rr (
    .clk(clk), .reset(reset), .req_i(req_a), .gnt_o(gnt_a), .gnt_valid_o(val_a), .gnt_idx_o(idx_a));
  round_robin_arbiter #(.N(4), .MODE(0), .HOLD(0)) u_fix (
    .clk(clk), .reset(reset), .req_i(req_b), .gnt_o(gnt_b), .gnt_valid_o(val_b), .gnt_idx_o(idx_b));
  round_robin_arbiter #(.N(4), .MODE(1), .HOLD(1)) u_hold (
    .clk(clk), .reset(reset), .req_i(req_c), .gnt_o(gnt_c), .gnt_valid_o(val_c), .gnt_idx_o(idx_c));
  round_robin_arbiter #(.N(5), .MODE(1), .HOLD(0)) u_n5 (
    .clk(clk), .reset(reset), .req_i(req_e), .gnt_o(gnt_e), .gnt_valid_o(val_e), .gnt_idx_o(idx_e));
  round_robin_arbiter #(.N(32), .MODE(1), .HOLD(0)) u_n32 (
    .clk(clk), .reset(reset), .req_i(req_d), .gnt_o(gnt_d), .gnt_valid_o(val_d), .gnt_idx_o(idx_d));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic cyc_a(input string t, input logic [3:0] r, input logic [3:0] eg, input logic [1:0] ei);
    req_a = r; @(negedge clk);
    check({t, "_gnt"}, gnt_a, eg); check({t, "_idx"}, idx_a, ei); check({t, "_val"}, val_a, eg != 0);
    next_cycle();
  endtask

  task automatic cyc_b(input string t, input logic [3:0] r, input logic [3:0] eg, input logic [1:0] ei);
    req_b = r; @(negedge clk);
    check({t, "_gnt"}, gnt_b, eg); check({t, "_idx"}, idx_b, ei); check({t, "_val"}, val_b, eg != 0);
    next_cycle();
  endtask

  task automatic cyc_c(input string t, input logic [3:0] r, input logic [3:0] eg, input logic [1:0] ei);
    req_c = r; @(negedge clk);
    check({t, "_gnt"}, gnt_c, eg); check({t, "_idx"}, idx_c, ei); check({t, "_val"}, val_c, eg != 0);
    next_cycle();
  endtask

  task automatic cyc_e(input string t, input logic [4:0] r, input logic [4:0] eg, input logic [2:0] ei);
    req_e = r; @(negedge clk);
    check({t, "_gnt"}, gnt_e, eg); check({t, "_idx"}, idx_e, ei); check({t, "_val"}, val_e, eg != 0);
    next_cycle();
  endtask

  initial begin
    int mptr;
    int k;
    bit found;
    int w[32];
    int maxw;
    logic [31:0] r;
    logic [31:0] eg;

    // outputs forced low while reset is held, whatever is requested
    req_a = 4'b1111;
    @(negedge clk);
    check("rst_gnt", gnt_a, 4'b0000); check("rst_val", val_a, 1'b0); check("rst_idx", idx_a, 2'd0);
    next_cycle();
    req_a = 4'b0000;
    do_reset();

    cyc_a("rr1", 4'b1010, 4'b0010, 2'd1);
    cyc_a("rr2", 4'b1010, 4'b1000, 2'd3);
    cyc_a("rr3", 4'b1010, 4'b0010, 2'd1);
    cyc_a("wrap3", 4'b1000, 4'b1000, 2'd3);
    cyc_a("wrap0", 4'b0101, 4'b0001, 2'd0);
    cyc_a("wrap2", 4'b0101, 4'b0100, 2'd2);
    cyc_a("idle", 4'b0000, 4'b0000, 2'd0);
    cyc_a("post_idle", 4'b1111, 4'b1000, 2'd3);

    reset = 1'b1; req_a = 4'b1111;
    @(negedge clk);
    check("midrst_gnt", gnt_a, 4'b0000); check("midrst_val", val_a, 1'b0); check("midrst_idx", idx_a, 2'd0);
    next_cycle();
    reset = 1'b0;
    cyc_a("after_rst", 4'b1111, 4'b0001, 2'd0);
    cyc_a("after_rst2", 4'b1111, 4'b0010, 2'd1);
    req_a = 4'b0000;

    do_reset();
    cyc_b("fix1", 4'b1010, 4'b0010, 2'd1);
    cyc_b("fix2", 4'b1010, 4'b0010, 2'd1);
    cyc_b("fix3", 4'b1010, 4'b0010, 2'd1);
    cyc_b("fix_idle", 4'b0000, 4'b0000, 2'd0);
    cyc_b("fix_hi", 4'b1100, 4'b0100, 2'd2);
    req_b = 4'b0000;

    do_reset();
    cyc_c("hold1", 4'b0011, 4'b0001, 2'd0);
    cyc_c("hold2", 4'b0011, 4'b0001, 2'd0);
    cyc_c("hold3", 4'b0011, 4'b0001, 2'd0);
    cyc_c("hold_drop", 4'b0010, 4'b0010, 2'd1);
    cyc_c("hold_new", 4'b0011, 4'b0010, 2'd1);
    cyc_c("hold_rel", 4'b0001, 4'b0001, 2'd0);
    req_c = 4'b0000;

    do_reset();
    cyc_e("n5_top", 5'b10000, 5'b10000, 3'd4);
    cyc_e("n5_wrap", 5'b10001, 5'b00001, 3'd0);
    cyc_e("n5_next", 5'b10001, 5'b10000, 3'd4);
    cyc_e("n5_wrap2", 5'b00011, 5'b00001, 3'd0);
    req_e = 5'b00000;

    // randomized N=32 run against a reference pointer model
    do_reset();
    mptr = 0;
    maxw = 0;
    for (int i = 0; i < 32; i++) w[i] = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      r = $urandom();
      if (cyc % 3 == 0) r = r & $urandom();
      if (cyc % 50 == 7) r = '0;
      if (cyc % 4 == 1) r = r & $urandom() & $urandom();
      req_d = r;
      found = 1'b0;
      k = 0;
      for (int i = 0; i < 32; i++) begin
        int j;
        j = (mptr + i) % 32;
        if (!found && r[j]) begin
          found = 1'b1;
          k = j;
        end
      end
      eg = found ? (32'd1 << k) : 32'd0;
      @(negedge clk);
      check("rnd_gnt", gnt_d, eg);
      check("rnd_idx", idx_d, found ? k : 0);
      check("rnd_subset", gnt_d & ~r, 32'd0);
      if (found) begin
        mptr = (k + 1) % 32;
        for (int i = 0; i < 32; i++) begin
          if (!r[i] || i == k) w[i] = 0;
          else begin
            w[i]++;
            if (w[i] > maxw) maxw = w[i];
          end
        end
      end else begin
        for (int i = 0; i < 32; i++) w[i] = 0;
      end
      next_cycle();
    end
    req_d = '0;
    check("starve_bound", maxw > 31, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
